// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
//
// Instruction fetch front end. It keeps a fetch PC, allows at most one
// outstanding read to a synchronous instruction memory, and buffers the
// returned words in a 2-entry FIFO that feeds the decode stage through a
// valid/ready handshake. A redirect flushes the FIFO, squashes the read in
// flight and reloads the fetch PC. A redirect to an illegal target sends the
// block into a sticky FAULT state that only rst can clear.
//
// Parameters
//   RESET_PC   byte address of the first fetch after reset
//   MEM_WORDS  number of valid 32-bit words in instruction memory
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   en           fetch enable; low blocks new fetches only
//   iaddr        byte address presented to instruction memory
//   idata        memory read data, valid the cycle after iaddr
//   redirect     branch/jump request
//   redirect_pc  redirect target byte address
//   ins          instruction at the FIFO head
//   ins_pc       byte address of ins
//   ins_valid    ins / ins_pc are valid
//   ins_ready    decode stage accepts ins
//   fault        sticky illegal-redirect flag
// ---------------------------------------------------------------------------
module fetch_sequencer #(
  parameter logic [5:0] RESET_PC  = 6'h00,
  parameter int         MEM_WORDS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [5:0]  iaddr,
  input  logic [31:0] idata,
  input  logic        redirect,
  input  logic [5:0]  redirect_pc,
  output logic [31:0] ins,
  output logic [5:0]  ins_pc,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic        fault
);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [5:0]  r_fetch_pc;
  logic        r_inflight;
  logic [5:0]  r_inflight_pc;
  logic [31:0] r_fifo_ins [2];
  logic [5:0]  r_fifo_pc  [2];
  logic        r_head;
  logic [1:0]  r_count;

  logic        w_run;
  logic        w_redirect;
  logic        w_illegal;
  logic [31:0] w_word_idx;
  logic        w_pop;
  logic        w_pop_eff;
  logic        w_push;
  logic        w_issue;
  logic [2:0]  w_occupancy;
  logic        w_wr_idx;

  assign w_run      = (r_state == ST_RUN);
  // Redirects are ignored once faulted; only rst leaves FAULT.
  assign w_redirect = w_run && redirect;

  assign w_word_idx = {26'd0, redirect_pc} >> 2;
  assign w_illegal  = (redirect_pc[1:0] != 2'b00) ||
                      (w_word_idx >= $unsigned(MEM_WORDS));

  assign ins_valid  = (r_count != 2'd0) && w_run;
  assign w_pop      = ins_valid && ins_ready;
  // A pop coinciding with a redirect is dropped along with the FIFO.
  assign w_pop_eff  = w_pop && !w_redirect;
  assign w_push     = r_inflight && !w_redirect;

  // Entries left after this cycle's pop plus the word still coming back must
  // leave room for one more, so the FIFO can never overflow.
  assign w_occupancy = {1'b0, r_count} - {2'b00, w_pop} + {2'b00, r_inflight};
  assign w_issue     = w_run && en && !redirect && (w_occupancy < 3'd2);

  // Tail slot; with count==2 no push can occur, so aliasing the head is safe.
  assign w_wr_idx   = r_head ^ r_count[0];

  assign iaddr      = r_fetch_pc;
  assign ins        = r_fifo_ins[r_head];
  assign ins_pc     = r_fifo_pc[r_head];
  assign fault      = (r_state == ST_FAULT);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state
  always_comb begin
    w_state_next = r_state;
    if (w_redirect && w_illegal) begin
      w_state_next = ST_FAULT;
    end
  end

  // Fetch PC, in-flight tracking and FIFO bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= 6'h00;
      r_head        <= 1'b0;
      r_count       <= 2'd0;
    end else if (w_redirect) begin
      r_inflight <= 1'b0;
      r_count    <= 2'd0;
      if (!w_illegal) begin
        r_fetch_pc <= redirect_pc;
      end
    end else begin
      if (w_issue) begin
        r_inflight    <= 1'b1;
        r_inflight_pc <= r_fetch_pc;
        r_fetch_pc    <= r_fetch_pc + 6'd4;
      end else if (w_push) begin
        r_inflight <= 1'b0;
      end
      if (w_pop_eff) begin
        r_head <= ~r_head;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop_eff};
    end
  end

  // FIFO storage, one register pair per slot
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_fifo_ins[gi] <= 32'h0;
          r_fifo_pc[gi]  <= 6'h0;
        end else if (w_push && (w_wr_idx == gi[0])) begin
          r_fifo_ins[gi] <= idata;
          r_fifo_pc[gi]  <= r_inflight_pc;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Bench for fetch_sequencer with a synchronous instruction memory holding
// mem[i] = 32'h1000_0000 + i. Directed phases push the hand-derived sequence
// of expected {ins, ins_pc} into a queue; a negedge monitor pops and compares
// every accepted instruction.
// ---------------------------------------------------------------------------
module tb_fetch_sequencer;

  logic        clk;
  logic        rst;
  logic        en;
  logic [5:0]  iaddr;
  logic [31:0] idata;
  logic        redirect;
  logic [5:0]  redirect_pc;
  logic [31:0] ins;
  logic [5:0]  ins_pc;
  logic        ins_valid;
  logic        ins_ready;
  logic        fault;

  int total = 0;
  int bad   = 0;

  logic [37:0] exp_q [$];

  fetch_sequencer #(
    .RESET_PC  (6'h00),
    .MEM_WORDS (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .iaddr       (iaddr),
    .idata       (idata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .ins         (ins),
    .ins_pc      (ins_pc),
    .ins_valid   (ins_valid),
    .ins_ready   (ins_ready),
    .fault       (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [5:0] a);
    return 32'h1000_0000 + {28'd0, a[5:2]};
  endfunction

  always @(posedge clk) idata <= mem_word(iaddr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic exp_push(input logic [5:0] pc);
    exp_q.push_back({mem_word(pc), pc});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      step();
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expected instructions never arrived", exp_q.size());
      exp_q.delete();
    end
    step();
    step();
  endtask

  // Monitor: every accepted instruction (outside a redirect cycle) is compared
  always @(negedge clk) begin
    if (!rst && ins_valid && ins_ready && !redirect) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected: ins_pc %0h ins %0h with nothing expected", ins_pc, ins);
      end else begin
        logic [37:0] e;
        e = exp_q.pop_front();
        chk("ins_pc", {26'd0, ins_pc}, {26'd0, e[5:0]});
        chk("ins", ins, e[37:6]);
        $display("accept pc=%0h ins=%0h", ins_pc, ins);
      end
    end
  end

  initial begin
    rst = 1'b0;
    en = 1'b0;
    redirect = 1'b0;
    redirect_pc = 6'h00;
    ins_ready = 1'b1;
    #1 rst = 1'b1;
    #1;
    chk("rst_iaddr", {26'd0, iaddr}, 32'h0);
    chk("rst_valid", {31'd0, ins_valid}, 32'd0);
    chk("rst_ins", ins, 32'h0);
    chk("rst_ins_pc", {26'd0, ins_pc}, 32'h0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    step();
    step();

    // Stream with wrap: 20 issues, pcs 0x00..0x3C then 0x00..0x0C
    rst = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 20; i++) exp_push(6'((4 * i) % 64));
    chk("stream_c0_valid", {31'd0, ins_valid}, 32'd0);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("stream_valid", {31'd0, ins_valid}, (i >= 1) ? 32'd1 : 32'd0);
    end
    // en low: in-flight word completes, iaddr frozen
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("en_low_iaddr", {26'd0, iaddr}, 32'h10);
    end
    drain();
    chk("drained_valid", {31'd0, ins_valid}, 32'd0);

    // Backpressure: ready low for 5 cycles mid-stream, resume at 0x10
    for (int i = 0; i < 8; i++) exp_push(6'(8'h10 + 8'(4 * i)));
    en = 1'b1;
    repeat (4) step();
    ins_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_iaddr", {26'd0, iaddr}, 32'h20);
      chk("bp_ins_pc", {26'd0, ins_pc}, 32'h18);
      chk("bp_ins", ins, 32'h1000_0006);
      chk("bp_valid", {31'd0, ins_valid}, 32'd1);
    end
    ins_ready = 1'b1;
    repeat (4) step();
    en = 1'b0;
    drain();

    // Redirect to 0x20 while the FIFO is full
    ins_ready = 1'b0;
    en = 1'b1;
    repeat (3) step();
    chk("pre_redir_iaddr", {26'd0, iaddr}, 32'h38);
    redirect = 1'b1;
    redirect_pc = 6'h20;
    ins_ready = 1'b1;
    step();
    redirect = 1'b0;
    chk("redir_valid", {31'd0, ins_valid}, 32'd0);
    chk("redir_iaddr", {26'd0, iaddr}, 32'h20);
    for (int i = 0; i < 4; i++) exp_push(6'(8'h20 + 8'(4 * i)));
    step();
    step();
    chk("redir_lat_valid", {31'd0, ins_valid}, 32'd1);
    chk("redir_lat_pc", {26'd0, ins_pc}, 32'h20);
    chk("redir_lat_ins", ins, 32'h1000_0008);
    step();
    step();
    en = 1'b0;
    drain();

    // Redirect with en low still reloads the PC
    redirect = 1'b1;
    redirect_pc = 6'h08;
    step();
    redirect = 1'b0;
    chk("redir_en0_iaddr", {26'd0, iaddr}, 32'h08);
    exp_push(6'h08);
    exp_push(6'h0C);
    en = 1'b1;
    step();
    step();
    en = 1'b0;
    drain();

    // Asynchronous reset between edges mid-stream
    exp_push(6'h10);
    exp_push(6'h14);
    exp_push(6'h18);
    en = 1'b1;
    repeat (5) step();
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, ins_valid}, 32'd0);
    chk("arst_ins", ins, 32'h0);
    chk("arst_ins_pc", {26'd0, ins_pc}, 32'h0);
    chk("arst_iaddr", {26'd0, iaddr}, 32'h0);
    chk("arst_fault", {31'd0, fault}, 32'd0);
    chk("arst_delivered", exp_q.size(), 32'd0);
    exp_q.delete();
    step();
    rst = 1'b0;
    exp_push(6'h00);
    exp_push(6'h04);
    exp_push(6'h08);
    repeat (3) step();
    en = 1'b0;
    drain();

    // Illegal redirect to 0x06: sticky fault, iaddr holds
    exp_push(6'h0C);
    en = 1'b1;
    repeat (3) step();
    redirect = 1'b1;
    redirect_pc = 6'h06;
    step();
    redirect = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("fault_flag", {31'd0, fault}, 32'd1);
      chk("fault_valid", {31'd0, ins_valid}, 32'd0);
      chk("fault_iaddr", {26'd0, iaddr}, 32'h18);
      step();
    end
    chk("fault_delivered", exp_q.size(), 32'd0);
    exp_q.delete();
    en = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("fault_cleared", {31'd0, fault}, 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("post_fault_valid", {31'd0, ins_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
